// File: rtl/systolic_array_pkg.sv
// Types shared by systolic_array and its load/drain neighbours.
// word_t is the accumulator word; drain_* items serve systolic_result_drain.
package systolic_array_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    DRAIN_IDLE   = 1'b0,
    DRAIN_STREAM = 1'b1
  } drain_state_t;

  // Width of a linear index over an n x n matrix, never narrower than one bit.
  function automatic int drain_idx_w(input int n);
    int w;
    w = $clog2(n * n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/systolic_result_drain.sv
// Snapshots the NxN psum matrix on done_i and streams it row-major over a
// valid/ready port, pulsing clear_o so the array can start the next tile.
module systolic_result_drain
  import systolic_array_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     done_i,
  input  word_t [N-1:0][N-1:0]     psum_i,
  output logic                     clear_o,
  output word_t                    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun
);

  localparam int IW = drain_idx_w(N);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);
  localparam logic [CW-1:0] LAST_RC  = CW'(N - 1);

  drain_state_t            state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           r_q, r_d, c_q, c_d;
  logic                    valid_q, valid_d;
  logic                    clear_q, clear_d;
  logic                    ovr_q, ovr_d;
  logic                    load;
  logic                    hs, at_last;
  word_t [N-1:0][N-1:0]    snap_q;

  assign hs      = valid_q && out_ready;
  assign at_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    r_d     = r_q;
    c_d     = c_q;
    valid_d = valid_q;
    clear_d = 1'b0;
    ovr_d   = ovr_q;
    load    = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (done_i) begin
          load    = 1'b1;
          state_d = DRAIN_STREAM;
          valid_d = 1'b1;
          clear_d = 1'b1;
          idx_d   = '0;
          r_d     = '0;
          c_d     = '0;
        end
      end
      DRAIN_STREAM: begin
        if (hs && at_last) begin
          idx_d = '0;
          r_d   = '0;
          c_d   = '0;
          // A done_i landing on the final handshake chains the next tile with no bubble.
          if (done_i) begin
            load    = 1'b1;
            clear_d = 1'b1;
          end else begin
            state_d = DRAIN_IDLE;
            valid_d = 1'b0;
          end
        end else begin
          if (hs) begin
            idx_d = idx_q + IW'(1);
            if (c_q == LAST_RC) begin
              c_d = '0;
              r_d = r_q + CW'(1);
            end else begin
              c_d = c_q + CW'(1);
            end
          end
          if (done_i) ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = DRAIN_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= DRAIN_IDLE;
      idx_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      clear_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      clear_q <= clear_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    snap_q <= '0;
    else if (load) snap_q <= psum_i;
  end

  assign out_data  = snap_q[r_q][c_q];
  assign out_valid = valid_q;
  assign out_last  = valid_q && at_last;
  assign busy      = (state_q == DRAIN_STREAM);
  assign clear_o   = clear_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: queue-based reference model checked every
// cycle, plus literal checks on the captured output sequence.
module tb_systolic_result_drain;
  import systolic_array_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b0;
  logic                 done_i = 1'b0;
  word_t [N-1:0][N-1:0] psum;
  logic                 clear_o, out_valid, out_ready, out_last, busy, overrun;
  word_t                out_data;

  int n_vec = 0;
  int n_err = 0;
  int clr_cnt = 0;
  word_t log_q[$];

  // reference model: words still owed to the sink, oldest first
  word_t mq[$];
  bit    m_clear = 1'b0;
  bit    m_ovr = 1'b0;
  bit    m_hs, m_accept;

  systolic_result_drain #(.N(N)) dut (
    .clk(clk), .n_rst(n_rst), .done_i(done_i), .psum_i(psum),
    .clear_o(clear_o), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mq.delete();
      m_clear = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      m_hs     = (mq.size() > 0) && out_ready;
      m_accept = (mq.size() == 0);
      m_clear  = 1'b0;
      if (m_hs) begin
        log_q.push_back(out_data);
        void'(mq.pop_front());
        if (mq.size() == 0) m_accept = 1'b1;
      end
      if (done_i) begin
        if (m_accept) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mq.push_back(psum[i][j]);
          m_clear = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      chk("out_valid", out_valid, mq.size() > 0);
      chk("busy", busy, mq.size() > 0);
      chk("out_last", out_last, mq.size() == 1);
      chk("clear_o", clear_o, m_clear);
      chk("overrun", overrun, m_ovr);
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      if (clear_o) clr_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_psum(input int base);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) psum[i][j] = word_t'(base + i * N + j);
  endtask

  task automatic fire_done();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1
  task automatic drain(input int mode);
    int cyc;
    cyc = 0;
    while (mq.size() > 0 && cyc < 300) begin
      if (mode == 1) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else           out_ready = 1'b1;
      step();
      cyc++;
    end
    out_ready = 1'b1;
    chk("drain_timeout", cyc < 300, 1'b1);
  endtask

  task automatic chk_seq(input string name, input int start, input int base);
    chk({name, "_len"}, log_q.size() >= start + N * N, 1'b1);
    if (log_q.size() >= start + N * N)
      for (int k = 0; k < N * N; k++) chk(name, log_q[start + k], base + k);
  endtask

  initial begin
    out_ready = 1'b1;
    set_psum(1);
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_clear", clear_o, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    step();
    n_rst = 1'b1;
    step();
    step();

    // basic
    log_q.delete(); clr_cnt = 0;
    fire_done();
    chk("basic_clear", clear_o, 1'b1);
    chk("basic_first", out_data, 32'd1);
    chk("basic_valid", out_valid, 1'b1);
    drain(0);
    chk("basic_busy_end", busy, 1'b0);
    chk_seq("basic_seq", 0, 1);
    chk("basic_clr_cnt", clr_cnt, 1);

    // backpressure
    log_q.delete();
    fire_done();
    drain(1);
    chk_seq("bp_seq", 0, 1);

    // snapshot isolation
    log_q.delete();
    fire_done();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) psum[i][j] = 32'hDEAD;
    drain(1);
    chk_seq("iso_seq", 0, 1);

    // overrun: second done while word 5 is presented
    log_q.delete(); clr_cnt = 0;
    set_psum(1);
    fire_done();
    while (log_q.size() < 4) step();
    set_psum(201);
    fire_done();
    chk("ovr_set", overrun, 1'b1);
    drain(0);
    chk_seq("ovr_seq", 0, 1);
    chk("ovr_clr_cnt", clr_cnt, 1);
    chk("ovr_sticky", overrun, 1'b1);
    log_q.delete();
    set_psum(1);
    fire_done();
    drain(0);
    chk_seq("ovr_after_seq", 0, 1);
    chk("ovr_still", overrun, 1'b1);

    // back-to-back: done coincident with last handshake
    log_q.delete(); clr_cnt = 0;
    fire_done();
    while (mq.size() > 1) step();
    set_psum(101);
    fire_done();
    chk("b2b_first", out_data, 32'd101);
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_clear", clear_o, 1'b1);
    drain(0);
    chk_seq("b2b_seq_a", 0, 1);
    chk_seq("b2b_seq_b", 16, 101);
    chk("b2b_clr_cnt", clr_cnt, 2);

    // reset mid-stream at word 8
    log_q.delete();
    set_psum(1);
    fire_done();
    while (log_q.size() < 7) step();
    n_rst = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ovr", overrun, 1'b0);
    step();
    n_rst = 1'b1;
    step(); step(); step();
    chk("mrst_idle", busy, 1'b0);
    log_q.delete();
    fire_done();
    chk("mrst_restart", out_data, 32'd1);
    drain(0);
    chk_seq("mrst_seq", 0, 1);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
